cla_add_seq: RTL and testbench
==============================

CLA_ADD_SEQ -- requirements
Module: cla_add_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; SHALL be a multiple of 4, minimum 8.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: ci  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high in RUN and DONE.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: s  output  WIDTH  registered sum.
REQ-011 Port: co  output  1  registered carry-out of the MSB.
REQ-012 Port: ovf  output  1  registered signed overflow: carry into MSB XOR co.

Function
REQ-013 Datapath SHALL be a single 4-bit carry-lookahead slice: g=a&b, p=a|b, c1..c3 and nibble carry-out from full lookahead equations, sum bit = a^b^carry-in of that bit.
REQ-014 FSM states: IDLE, RUN, DONE; encoding free.
REQ-015 IDLE: start=1 -> latch a, b, ci into operand/carry registers, clear nibble index to 0, enter RUN; start=0 -> stay.
REQ-016 RUN: each cycle processes nibble[index] with the carry register; writes 4 sum bits into s[4*index+3:4*index]; carry register <= nibble carry-out; index increments.
REQ-017 RUN: when index = WIDTH/4-1 is processed, co <= nibble carry-out, ovf <= c3 XOR nibble carry-out, next state DONE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 Latency: start sampled at edge 0 -> done high during cycle WIDTH/4+1 (9 cycles for WIDTH=32); next start accepted in the cycle after done.
REQ-020 start while busy=1 SHALL be ignored, including start coincident with done; operand inputs are don't-care outside acceptance.
REQ-021 s, co, ovf SHALL hold final values from done until the next accepted start; undefined-intermediate nibbles of s may be visible during RUN.
REQ-022 Index SHALL not wrap: RUN terminates on last nibble, never revisits nibble 0.

Reset
REQ-023 reset_n=0 SHALL immediately force IDLE, index=0, carry register=0, s=0, co=0, ovf=0, busy=0, done=0, regardless of clock.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; first start after reset release starts a fresh operation.

Configuration
REQ-025 Macro CLA_ADD_SEQ_SUB_EN: when defined, an extra input port op (1 bit) exists; op=1 at acceptance latches ~b and forces carry-in to 1 (A-B), op=0 is normal add; co=1 means no borrow.
REQ-026 Without CLA_ADD_SEQ_SUB_EN: no op port; block performs A+B+ci only.

Verification
REQ-027 WIDTH=32, a=0xFFFFFFFF, b=0x00000001, ci=0, start -> done 9 cycles later, s=0x00000000, co=1, ovf=0.
REQ-028 a=0x12345678, b=0x11111111, ci=1 -> s=0x2345678A, co=0, ovf=0; busy high exactly 9 cycles.
REQ-029 a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, ovf=1.
REQ-030 start pulsed at cycles 3 and at the done cycle of an active operation -> ignored; exactly one done pulse, result unchanged.
REQ-031 reset_n low during RUN cycle 4 -> busy, done, s, co, ovf all 0 immediately; no done pulse; new start after release completes correctly.
REQ-032 CLA_ADD_SEQ_SUB_EN defined, op=1, a=5, b=7 -> s=0xFFFFFFFE, co=0; op=1, a=7, b=5 -> s=0x00000002, co=1.

Source files
------------

// File: rtl/cla_add_seq.sv
// cla_add_seq: nibble-serial adder built around one 4-bit carry-lookahead slice, WIDTH/4 cycles per add.
// Optional subtract support (op port, A-B) is enabled by defining CLA_ADD_SEQ_SUB_EN.
module cla_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef CLA_ADD_SEQ_SUB_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             c_q, c_d, co_q, co_d, ovf_q, ovf_d;
    logic [3:0]       nib_a, nib_b, g, p, c, sum;
    logic             c4;

    // Lookahead slice over the nibble selected by the index, fed by the carry register
    always_comb begin
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = b_q[{idx_q, 2'b00} +: 4];
        g     = nib_a & nib_b;
        p     = nib_a | nib_b;
        c[0]  = c_q;
        c[1]  = g[0] | (p[0] & c_q);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
        c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & c_q);
        sum   = nib_a ^ nib_b ^ c;
    end

    // Sequencing: capture operands in IDLE, one nibble per RUN cycle, single-cycle DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a;
`ifdef CLA_ADD_SEQ_SUB_EN
                b_d     = op ? ~b : b;
                c_d     = op | ci;
`else
                b_d     = b;
                c_d     = ci;
`endif
                idx_d   = '0;
            end
            RUN: begin
                s_d[{idx_q, 2'b00} +: 4] = sum;
                c_d = c4;
                if (idx_q == IW'(NIB - 1)) begin
                    co_d    = c4;
                    ovf_d   = c[3] ^ c4;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign s    = s_q;
    assign co   = co_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_add_seq.sv
// tb_cla_add_seq: directed self-checking bench for cla_add_seq (WIDTH=32).
module tb_cla_add_seq;
    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, ci_i = 1'b0;
    logic [31:0] a_i = '0, b_i = '0;
`ifdef CLA_ADD_SEQ_SUB_EN
    logic        op_i = 1'b0;
`endif
    logic        busy, done, co, ovf;
    logic [31:0] s;
    int          n_cmp = 0, n_fail = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    cla_add_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a_i), .b(b_i), .ci(ci_i),
`ifdef CLA_ADD_SEQ_SUB_EN
        .op(op_i),
`endif
        .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Presents one start pulse; returns at the falling edge of the first RUN cycle.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        @(negedge clk);
        a_i = av; b_i = bv; ci_i = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_i = 32'hDEADBEEF; b_i = 32'h0BADF00D; ci_i = ~cv;
    endtask

    // Counts cycles (first RUN cycle = 1) until done, bounded; also counts busy cycles.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 1; bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        if (busy === 1'b1) bcnt++;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({busy, done, co, ovf, s} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, co, ovf, s});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_vectors;
        vec_t v[8];
        int   cyc, bcnt;
        v = '{
            '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0},
            '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0},
            '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1},
            '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1},
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
            '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0},
            '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1, 1'b0},
            '{32'h89ABCDEF, 32'h76543210, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0}
        };
        for (int i = 0; i < 8; i++) begin
            launch(v[i].a, v[i].b, v[i].ci);
            wait_done(cyc, bcnt);
            n_cmp++;
            if (cyc !== 9) begin n_fail++; $display("FAIL vec%0d latency: got %0d expected 9", i, cyc); end
            n_cmp++;
            if (bcnt !== 9) begin n_fail++; $display("FAIL vec%0d busy_cycles: got %0d expected 9", i, bcnt); end
            n_cmp++;
            if (s !== v[i].s) begin n_fail++; $display("FAIL vec%0d s: got %h expected %h", i, s, v[i].s); end
            n_cmp++;
            if (co !== v[i].co) begin n_fail++; $display("FAIL vec%0d co: got %b expected %b", i, co, v[i].co); end
            n_cmp++;
            if (ovf !== v[i].ovf) begin n_fail++; $display("FAIL vec%0d ovf: got %b expected %b", i, ovf, v[i].ovf); end
            @(negedge clk);
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL vec%0d after_done busy/done: got %b expected 00", i, {busy, done});
            end
            @(negedge clk);
            @(negedge clk);
            n_cmp++;
            if ({s, co, ovf} !== {v[i].s, v[i].co, v[i].ovf}) begin
                n_fail++;
                $display("FAIL vec%0d hold: got %h expected %h", i, {s, co, ovf}, {v[i].s, v[i].co, v[i].ovf});
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bcnt;
        launch(32'h00000010, 32'h00000020, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++;
        if (s !== 32'h00000030) begin n_fail++; $display("FAIL b2b_first s: got %h expected 00000030", s); end
        launch(32'hFFFF0000, 32'h00010000, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++;
        if (cyc !== 9) begin n_fail++; $display("FAIL b2b_second latency: got %0d expected 9", cyc); end
        n_cmp++;
        if ({s, co} !== {32'h00000000, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second s/co: got %h expected %h", {s, co}, {32'h00000000, 1'b1});
        end
    endtask

    task automatic test_ignore_start;
        int ndone = 0, first = 0;
        launch(32'h12345678, 32'h11111111, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a_i = 32'hFFFFFFFF; b_i = 32'hFFFFFFFF; ci_i = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 4; k < 30; k++) begin
            if (first != 0 && k == first + 1) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_at_done busy: got %b expected 0", busy);
                end
            end
            start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) first = k;
                a_i = 32'h00000000; b_i = 32'h00000000; ci_i = 1'b0; start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (ndone !== 1) begin n_fail++; $display("FAIL ignore_start done_count: got %0d expected 1", ndone); end
        n_cmp++;
        if (first !== 9) begin n_fail++; $display("FAIL ignore_start latency: got %0d expected 9", first); end
        n_cmp++;
        if ({s, co, ovf} !== {32'h2345678A, 2'b00}) begin
            n_fail++;
            $display("FAIL ignore_start result: got %h expected %h", {s, co, ovf}, {32'h2345678A, 2'b00});
        end
    endtask

    task automatic test_reset_midrun;
        int ndone = 0, cyc, bcnt;
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun busy: got %b expected 1", busy); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, co, ovf, s} !== 36'h0) begin
            n_fail++;
            $display("FAIL async_reset outputs: got %h expected 0", {busy, done, co, ovf, s});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        n_cmp++;
        if (ndone !== 0) begin n_fail++; $display("FAIL reset_abort done_count: got %0d expected 0", ndone); end
        launch(32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++;
        if (cyc !== 9) begin n_fail++; $display("FAIL post_reset latency: got %0d expected 9", cyc); end
        n_cmp++;
        if ({s, co, ovf} !== {32'h80000000, 2'b01}) begin
            n_fail++;
            $display("FAIL post_reset result: got %h expected %h", {s, co, ovf}, {32'h80000000, 2'b01});
        end
    endtask

`ifdef CLA_ADD_SEQ_SUB_EN
    task automatic test_sub;
        int cyc, bcnt;
        op_i = 1'b1;
        launch(32'd5, 32'd7, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++;
        if ({s, co} !== {32'hFFFFFFFE, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_5_7: got %h expected %h", {s, co}, {32'hFFFFFFFE, 1'b0});
        end
        launch(32'd7, 32'd5, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++;
        if ({s, co} !== {32'h00000002, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_7_5: got %h expected %h", {s, co}, {32'h00000002, 1'b1});
        end
        op_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_ignore_start();
        test_reset_midrun();
`ifdef CLA_ADD_SEQ_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
